plic_irq_gateway: RTL and testbench
===================================

// Module: plic_irq_gateway
// PURPOSE
//  Interrupt gateway directly upstream of the PLIC; drives its 16-bit plic_irq_port.
//  Per source: synchronises an async raw IRQ, applies polarity, and selects level or edge mode.
//  In edge mode it counts edges and holds the output high until the PLIC claims that ID, so no edge is lost.
//  Configured over an ICB slave port with the same single-cycle-ready, 1-cycle-read-latency protocol as the PLIC.
// PARAMETERS
//  N_SRC        16  number of sources; bit 0 is reserved and its output is tied to 0
//  SYNC_STAGES  2   synchroniser depth in flops (>=2)
//  CNT_W        2   edge-pending counter width; saturates at 2^CNT_W-1
// PORTS
//  clk                 in   1      clock
//  rst                 in   1      asynchronous reset, active-high
//  irq_raw_i           in   N_SRC  raw asynchronous interrupt lines
//  icb_cmd_valid       in   1      ICB command valid
//  icb_cmd_ready       out  1      ICB command ready; constant 1
//  icb_cmd_addr        in   32     byte address; only [7:0] decoded
//  icb_cmd_read        in   1      1=read, 0=write
//  icb_cmd_wdata       in   32     write data
//  icb_cmd_wmask       in   4      write byte mask; ignored, full-word writes only
//  icb_rsp_valid       out  1      read response valid
//  icb_rsp_ready       in   1      read response accepted
//  icb_rsp_err         out  1      constant 0
//  icb_rsp_rdata       out  32     read data
//  claim_valid_i       in   1      PLIC claim strobe (core_ex_trap_ready)
//  claim_id_i          in   5      claimed source ID (PLIC core_ex_trap_id)
//  plic_irq_port_o     out  N_SRC  registered request lines to the PLIC
// BEHAVIOUR
//  Reset (async, rst=1):
//   - All sync flops, prev, cnt, MODE, POL and plic_irq_port_o are cleared to 0.
//   - icb_rsp_valid=0 and icb_rsp_rdata=0.
//  Registers (addr[7:0]):
//   - 0x00 MODE rw: bit i=1 selects edge mode for source i.
//   - 0x04 POL rw: bit i=1 means active-low / falling edge.
//   - 0x08 SWTRIG wo: write-1 injects one edge event into each selected source in edge mode; reads return 0.
//   - 0x0C PEND ro: bit i = (cnt[i]!=0).
//   - Bit 0 of MODE and POL is hardwired to 0. Unmapped reads return 0; unmapped writes are ignored.
//  ICB protocol:
//   - A write takes effect at the clock edge where cmd_valid & ~read.
//   - A read sets rsp_valid and registers rdata on the next edge.
//   - rsp_valid holds until rsp_valid & rsp_ready.
//   - A new read arriving while rsp_valid=1 overwrites rdata and keeps rsp_valid=1.
//  Per-source datapath, for i = 1..N_SRC-1:
//   - s = SYNC_STAGES-deep sync of irq_raw_i[i], then a = s ^ POL[i].
//   - prev <= a every cycle; edge = a & ~prev.
//  Edge-mode counter:
//   - inc = edge | swtrig[i]; dec = claim_valid_i & (claim_id_i==i) & (cnt!=0).
//   - inc & ~dec: cnt+1, saturating at max (further edges are dropped).
//   - dec & ~inc: cnt-1.
//   - inc & dec: cnt unchanged.
//   - A claim with cnt==0 is ignored.
//  Output:
//   - plic_irq_port_o[i] <= MODE[i] ? (cnt_next!=0) : a.
//   - Level mode has no memory; cnt is held at 0 while MODE[i]=0.
//  Latency:
//   - The raw transition is captured by the first sync flop.
//   - plic_irq_port_o changes SYNC_STAGES+1 clocks later in both modes.
//  Config changes:
//   - A write to MODE that changes bit i clears cnt[i].
//   - A write to POL reloads prev[i] with the new (s ^ POL[i]), so no spurious edge results.
//  Claim ID 0 and IDs >= N_SRC are ignored.
//  Repeated edges: with cnt=2, the output stays high across the first claim. The PLIC IP re-samples it high, so the source is serviced twice.
// TESTING
//  1. Level mode, POL=0: irq_raw_i[3] 0->1 -> port[3]=1 after SYNC_STAGES+1=3 clocks; raw falls -> port[3]=0 3 clocks later.
//  2. Edge mode, source 5:
//     - 1-cycle raw pulse -> port[5]=1 and stays 1 for 100 cycles.
//     - claim_valid_i=1, claim_id_i=5 -> port[5]=0 next clock; PEND reads 0.
//  3. Edge mode, source 2, three pulses before any claim -> PEND[2]=1; port stays 1 through 2 claims and drops after the 3rd. A 4th pulse before any claim saturates the count: only 3 claims are needed.
//  4. Same-cycle edge and claim on source 7 with cnt=1 -> cnt stays 1 and port[7] stays 1.
//  5. POL change: raw[4]=0 in edge mode, write POL=0x10 -> no edge and port[4]=0. Raw 1->0 then produces an edge.
//  6. ICB:
//     - Write MODE=0xFFFF, read back -> 0xFFFE.
//     - Read 0x40 -> 0.
//     - Hold rsp_ready=0 for 5 cycles -> rsp_valid held for 5 cycles.
//     - Assert rst mid-read -> rsp_valid=0 and all ports 0 immediately.

Source files
------------

// File: rtl/plic_irq_gateway_if.sv
// ICB configuration bus between a bus master and the PLIC interrupt gateway.
// Single-cycle command acceptance, registered read response.
interface plic_irq_gateway_if;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [3:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic        icb_rsp_err;
    logic [31:0] icb_rsp_rdata;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
    );
endinterface

// File: rtl/plic_irq_gateway.sv
// Interrupt gateway in front of the PLIC: synchronises raw IRQs, applies polarity and
// turns edges into claim-counted pending requests so no edge is lost.
module plic_irq_gateway #(
    parameter int unsigned N_SRC       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SRC-1:0]   irq_raw_i,
    plic_irq_gateway_if.slave  icb,
    input  logic               claim_valid_i,
    input  logic [4:0]         claim_id_i,
    output logic [N_SRC-1:0]   plic_irq_port_o
);

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [N_SRC-1:0] SrcMask = {{(N_SRC-1){1'b1}}, 1'b0};

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] prev_q, prev_d;
    logic [N_SRC-1:0] mode_q, mode_d;
    logic [N_SRC-1:0] pol_q, pol_d;
    logic [CNT_W-1:0] cnt_q [N_SRC];
    logic [CNT_W-1:0] cnt_d [N_SRC];
    logic [N_SRC-1:0] port_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [N_SRC-1:0] sync_out, act, edge_det, swtrig, mode_chg, pend, inc, dec;
    logic [N_SRC-1:0] wdata_src;
    logic [7:0]       addr;
    logic             wr_en, rd_en, wr_mode, wr_pol, wr_swtrig;
    logic             unused_bits;

    assign addr      = icb.icb_cmd_addr[7:0];
    assign wr_en     = icb.icb_cmd_valid & ~icb.icb_cmd_read;
    assign rd_en     = icb.icb_cmd_valid & icb.icb_cmd_read;
    assign wr_mode   = wr_en & (addr == 8'h00);
    assign wr_pol    = wr_en & (addr == 8'h04);
    assign wr_swtrig = wr_en & (addr == 8'h08);
    assign wdata_src = icb.icb_cmd_wdata[N_SRC-1:0] & SrcMask;

    assign unused_bits = ^{icb.icb_cmd_wmask, icb.icb_cmd_addr[31:8],
                           icb.icb_cmd_wdata[31:N_SRC]};

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign act      = (sync_out ^ pol_q) & SrcMask;
    assign edge_det = act & ~prev_q;

    assign icb.icb_cmd_ready = 1'b1;
    assign icb.icb_rsp_err   = 1'b0;
    assign icb.icb_rsp_valid = rsp_valid_q;
    assign icb.icb_rsp_rdata = rdata_q;

    // Reloading prev with the new polarity hides the polarity flip from the edge detector.
    always_comb begin
        mode_d   = wr_mode ? wdata_src : mode_q;
        pol_d    = wr_pol ? wdata_src : pol_q;
        prev_d   = wr_pol ? ((sync_out ^ wdata_src) & SrcMask) : act;
        swtrig   = wr_swtrig ? wdata_src : '0;
        mode_chg = wr_mode ? (wdata_src ^ mode_q) : '0;
    end

    always_comb begin
        pend   = '0;
        inc    = '0;
        dec    = '0;
        port_d = '0;
        for (int i = 0; i < N_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
            pend[i]  = (cnt_q[i] != '0);
            inc[i]   = edge_det[i] | swtrig[i];
            dec[i]   = claim_valid_i & (int'(claim_id_i) == i) & pend[i];
            if (i == 0 || !mode_q[i] || mode_chg[i]) begin
                cnt_d[i] = '0;
            end else if (inc[i] && !dec[i]) begin
                if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec[i] && !inc[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            if (i != 0) port_d[i] = mode_q[i] ? (cnt_d[i] != '0) : act[i];
        end
    end

    // A new read replaces pending data even if the previous response is still unaccepted.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        if (rsp_valid_q && icb.icb_rsp_ready) rsp_valid_d = 1'b0;
        if (rd_en) begin
            rsp_valid_d = 1'b1;
            case (addr)
                8'h00:   rdata_d = 32'(mode_q);
                8'h04:   rdata_d = 32'(pol_q);
                8'h0C:   rdata_d = 32'(pend);
                default: rdata_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            for (int i = 0; i < N_SRC; i++) cnt_q[i] <= '0;
            prev_q          <= '0;
            mode_q          <= '0;
            pol_q           <= '0;
            plic_irq_port_o <= '0;
            rsp_valid_q     <= 1'b0;
            rdata_q         <= 32'h0;
        end else begin
            sync_q[0] <= irq_raw_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            for (int i = 0; i < N_SRC; i++) cnt_q[i] <= cnt_d[i];
            prev_q          <= prev_d;
            mode_q          <= mode_d;
            pol_q           <= pol_d;
            plic_irq_port_o <= port_d;
            rsp_valid_q     <= rsp_valid_d;
            rdata_q         <= rdata_d;
        end
    end

endmodule

// File: tb/tb_plic_irq_gateway.sv
// Self-checking bench for plic_irq_gateway: directed scenarios plus a randomized run
// compared against a per-source pending-count reference model.
module tb_plic_irq_gateway;

    localparam int SYNC = 2;
    localparam int MAXC = 3;

    logic        clk;
    logic        rst;
    logic [15:0] raw;
    logic        claim_valid;
    logic [4:0]  claim_id;
    logic [15:0] port;

    int checks;
    int errors;

    plic_irq_gateway_if icb ();

    plic_irq_gateway #(
        .N_SRC       (16),
        .SYNC_STAGES (SYNC),
        .CNT_W       (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .irq_raw_i       (raw),
        .icb             (icb),
        .claim_valid_i   (claim_valid),
        .claim_id_i      (claim_id),
        .plic_irq_port_o (port)
    );

    always #5 clk = ~clk;

    // Reference model: raw is seen SYNC clocks late; each edge-mode source holds a
    // number of outstanding requests that edges add to and claims remove from.
    logic [15:0] m_hist [SYNC];
    logic [15:0] m_prev, m_mode, m_pol, m_exp;
    int          m_cnt [16];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC; k++) m_hist[k] <= '0;
            for (int i = 0; i < 16; i++) m_cnt[i] <= 0;
            m_prev <= '0;
            m_mode <= '0;
            m_pol  <= '0;
            m_exp  <= '0;
        end else begin : step
            logic [15:0] s;
            logic [15:0] wd;
            logic [7:0]  a8;
            logic        w, act, inc, dec;
            int          c;
            s  = m_hist[SYNC-1];
            w  = icb.icb_cmd_valid && !icb.icb_cmd_read;
            a8 = icb.icb_cmd_addr[7:0];
            wd = icb.icb_cmd_wdata[15:0];
            for (int i = 1; i < 16; i++) begin
                act = s[i] ^ m_pol[i];
                inc = (act && !m_prev[i]) || (w && a8 == 8'h08 && wd[i]);
                dec = claim_valid && int'(claim_id) == i && m_cnt[i] > 0;
                c = m_cnt[i];
                if (!m_mode[i]) c = 0;
                else if (inc && !dec) c = (c < MAXC) ? c + 1 : MAXC;
                else if (dec && !inc) c = c - 1;
                if (w && a8 == 8'h00 && wd[i] != m_mode[i]) c = 0;
                m_cnt[i]  <= c;
                m_exp[i]  <= m_mode[i] ? (c > 0) : act;
                m_prev[i] <= (w && a8 == 8'h04) ? (s[i] ^ wd[i]) : act;
            end
            m_exp[0] <= 1'b0;
            if (w && a8 == 8'h00) m_mode <= wd & 16'hFFFE;
            if (w && a8 == 8'h04) m_pol <= wd & 16'hFFFE;
            m_hist[0] <= raw;
            for (int k = 1; k < SYNC; k++) m_hist[k] <= m_hist[k-1];
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic icb_write(input logic [7:0] a, input logic [31:0] d);
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_addr  = {24'h0, a};
        icb.icb_cmd_wdata = d;
        @(negedge clk);
        icb.icb_cmd_valid = 1'b0;
    endtask

    task automatic icb_read(input logic [7:0] a, output logic [31:0] d);
        icb.icb_rsp_ready = 1'b1;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = 1'b1;
        icb.icb_cmd_addr  = {24'h0, a};
        @(negedge clk);
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_read  = 1'b0;
        d = icb.icb_rsp_rdata;
    endtask

    task automatic pulse(input int src);
        raw[src] = 1'b1;
        @(negedge clk);
        raw[src] = 1'b0;
        @(negedge clk);
    endtask

    task automatic claim(input int src);
        claim_valid = 1'b1;
        claim_id    = 5'(src);
        @(negedge clk);
        claim_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        checks++;
        if (port !== 16'h0) begin
            errors++; $display("FAIL reset_port: got %h expected 0000", port);
        end
        checks++;
        if (icb.icb_rsp_valid !== 1'b0 || icb.icb_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b rdata=%h expected 0/0",
                     icb.icb_rsp_valid, icb.icb_rsp_rdata);
        end
        checks++;
        if (icb.icb_cmd_ready !== 1'b1 || icb.icb_rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL const_outputs: got ready=%b err=%b expected 1/0",
                     icb.icb_cmd_ready, icb.icb_rsp_err);
        end
        rst = 1'b0;
        cyc(1);
        icb_read(8'h00, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_mode: got %h expected 0", d); end
        icb_read(8'h04, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_pol: got %h expected 0", d); end
    endtask

    task automatic test_level;
        raw[3] = 1'b1;
        cyc(2);
        checks++;
        if (port[3] !== 1'b0) begin errors++; $display("FAIL level_rise_early: got 1 expected 0"); end
        cyc(1);
        checks++;
        if (port[3] !== 1'b1) begin errors++; $display("FAIL level_rise: got 0 expected 1"); end
        raw[3] = 1'b0;
        cyc(2);
        checks++;
        if (port[3] !== 1'b1) begin errors++; $display("FAIL level_fall_early: got 0 expected 1"); end
        cyc(1);
        checks++;
        if (port[3] !== 1'b0) begin errors++; $display("FAIL level_fall: got 1 expected 0"); end
    endtask

    task automatic test_edge;
        logic [31:0] d;
        icb_write(8'h00, 32'h20);
        pulse(5);
        cyc(1);
        checks++;
        if (port[5] !== 1'b1) begin errors++; $display("FAIL edge_set: got 0 expected 1"); end
        cyc(100);
        checks++;
        if (port[5] !== 1'b1) begin errors++; $display("FAIL edge_hold: got 0 expected 1"); end
        icb_read(8'h0C, d);
        checks++;
        if (d !== 32'h20) begin errors++; $display("FAIL edge_pend: got %h expected 00000020", d); end
        claim(5);
        checks++;
        if (port[5] !== 1'b0) begin errors++; $display("FAIL edge_claim: got 1 expected 0"); end
        icb_read(8'h0C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL edge_pend_clr: got %h expected 0", d); end
    endtask

    task automatic test_multi_edge;
        logic [31:0] d;
        icb_write(8'h00, 32'h4);
        for (int n = 3; n <= 4; n++) begin
            for (int p = 0; p < n; p++) pulse(2);
            cyc(2);
            icb_read(8'h0C, d);
            checks++;
            if (d !== 32'h4) begin errors++; $display("FAIL multi_pend: got %h expected 00000004", d); end
            for (int k = 1; k <= 3; k++) begin
                claim(2);
                checks++;
                if (port[2] !== (k < 3)) begin
                    errors++;
                    $display("FAIL multi_claim%0d: got %b expected %b", k, port[2], k < 3);
                end
            end
        end
    endtask

    task automatic test_same_cycle;
        logic [31:0] d;
        icb_write(8'h00, 32'h80);
        pulse(7);
        cyc(1);
        raw[7] = 1'b1;
        @(negedge clk);
        raw[7] = 1'b0;
        @(negedge clk);
        claim(7);
        checks++;
        if (port[7] !== 1'b1) begin errors++; $display("FAIL same_cycle_port: got 0 expected 1"); end
        icb_read(8'h0C, d);
        checks++;
        if (d !== 32'h80) begin errors++; $display("FAIL same_cycle_pend: got %h expected 00000080", d); end
        claim(7);
        checks++;
        if (port[7] !== 1'b0) begin errors++; $display("FAIL same_cycle_last: got 1 expected 0"); end
    endtask

    task automatic test_pol_change;
        logic [31:0] d;
        icb_write(8'h00, 32'h10);
        icb_write(8'h04, 32'h10);
        cyc(5);
        checks++;
        if (port[4] !== 1'b0) begin errors++; $display("FAIL pol_no_edge: got 1 expected 0"); end
        icb_read(8'h0C, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL pol_pend: got %h expected 0", d); end
        raw[4] = 1'b1;
        cyc(5);
        checks++;
        if (port[4] !== 1'b0) begin errors++; $display("FAIL pol_rise_ignored: got 1 expected 0"); end
        raw[4] = 1'b0;
        cyc(3);
        checks++;
        if (port[4] !== 1'b1) begin errors++; $display("FAIL pol_fall_edge: got 0 expected 1"); end
        claim(4);
        icb_write(8'h04, 32'h0);
    endtask

    task automatic test_icb;
        logic [31:0] d;
        icb_write(8'h00, 32'hFFFF);
        icb_read(8'h00, d);
        checks++;
        if (d !== 32'hFFFE) begin errors++; $display("FAIL mode_readback: got %h expected 0000fffe", d); end
        icb_read(8'h40, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected 0", d); end
        icb_read(8'h08, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL swtrig_read: got %h expected 0", d); end
        icb_write(8'h00, 32'h0);
        icb_write(8'h04, 32'hF0);
        cyc(4);
        checks++;
        if (port !== 16'h00F0) begin errors++; $display("FAIL level_pol: got %h expected 00f0", port); end
        icb.icb_rsp_ready = 1'b0;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_read  = 1'b1;
        icb.icb_cmd_addr  = 32'h0;
        @(negedge clk);
        icb.icb_cmd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (icb.icb_rsp_valid !== 1'b1) begin
                errors++; $display("FAIL rsp_hold%0d: got 0 expected 1", k);
            end
            cyc(1);
        end
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_addr  = 32'h4;
        @(negedge clk);
        icb.icb_cmd_valid = 1'b0;
        checks++;
        if (icb.icb_rsp_valid !== 1'b1 || icb.icb_rsp_rdata !== 32'hF0) begin
            errors++;
            $display("FAIL rsp_overwrite: got valid=%b rdata=%h expected 1/000000f0",
                     icb.icb_rsp_valid, icb.icb_rsp_rdata);
        end
        icb.icb_rsp_ready = 1'b1;
        cyc(1);
        checks++;
        if (icb.icb_rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_accept: got 1 expected 0"); end
        icb.icb_rsp_ready = 1'b0;
        icb.icb_cmd_valid = 1'b1;
        @(negedge clk);
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_read  = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (icb.icb_rsp_valid !== 1'b0 || port !== 16'h0 || icb.icb_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b port=%h rdata=%h expected 0/0000/0",
                     icb.icb_rsp_valid, port, icb.icb_rsp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
        icb.icb_rsp_ready = 1'b1;
        icb_read(8'h04, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL reset_pol_clear: got %h expected 0", d); end
    endtask

    task automatic test_random;
        logic [31:0] d;
        logic [31:0] exp_pend;
        int          r;
        icb_write(8'h00, $urandom & 32'hFFFE);
        icb_write(8'h04, $urandom & 32'hFFFF);
        for (int t = 0; t < 800; t++) begin
            checks++;
            if (port !== m_exp) begin
                errors++; $display("FAIL random_port@%0d: got %h expected %h", t, port, m_exp);
            end
            raw         = raw ^ 16'($urandom & $urandom);
            claim_valid = ($urandom_range(0, 2) == 0);
            claim_id    = 5'($urandom_range(0, 20));
            r = $urandom_range(0, 39);
            icb.icb_cmd_valid = (r < 5);
            icb.icb_cmd_read  = 1'b0;
            icb.icb_cmd_addr  = (r == 0) ? 32'h0 : (r == 1) ? 32'h4 : 32'h8;
            icb.icb_cmd_wdata = $urandom;
            @(negedge clk);
        end
        icb.icb_cmd_valid = 1'b0;
        claim_valid = 1'b0;
        exp_pend = '0;
        for (int i = 0; i < 16; i++) exp_pend[i] = (m_cnt[i] != 0);
        icb_read(8'h0C, d);
        checks++;
        if (d !== exp_pend) begin errors++; $display("FAIL random_pend: got %h expected %h", d, exp_pend); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        clk = 1'b0;
        rst = 1'b0;
        raw = '0;
        claim_valid = 1'b0;
        claim_id = '0;
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_addr  = '0;
        icb.icb_cmd_wdata = '0;
        icb.icb_cmd_wmask = 4'hF;
        icb.icb_rsp_ready = 1'b1;
        #1 rst = 1'b1;
        cyc(3);
        test_reset();
        test_level();
        test_edge();
        test_multi_edge();
        test_same_cycle();
        test_pol_change();
        test_icb();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
